// File: rtl/cmd_seq_multi_if.sv
// 8-bit register bus shared by the FE command/readout blocks.
// Handshake: BUS_WR and BUS_RD are single-cycle strobes. A write commits at the sampling
// edge, and a read loads BUS_DATA_OUT at that same edge. There is no back-pressure.
interface cmd_seq_multi_if;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  BUS_DATA_OUT;

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR,
    input  BUS_DATA_OUT
  );

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR,
    output BUS_DATA_OUT
  );
endinterface

// File: rtl/cmd_seq_multi.sv
// Command sequencer: serialises a bus-writable byte memory MSB-first onto masked output lines,
// with start address, repeat count, inter-repetition gap, abort and configuration snapshot.
module cmd_seq_multi #(
  parameter int         MEM_BYTES = 2048,
  parameter int         OUT_LINES = 4,
  parameter logic [7:0] VERSION   = 8'd2
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  cmd_seq_multi_if.slave       bus,
  input  logic                 CMD_EXT_START,
  output logic [OUT_LINES-1:0] CMD_DATA,
  output logic                 CMD_READY,
  output logic                 CMD_READY_FLAG,
  output logic                 CMD_START_FLAG,
  output logic [1:0]           state_dbg
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // bus decode
  logic        reg_hit, mem_hit, reg_wr;
  logic [3:0]  reg_sel;
  logic [15:0] mem_off;
  logic        soft_rst, bus_start, abort_req;

  assign reg_hit   = (bus.BUS_ADD < 16'd16);
  assign mem_hit   = (bus.BUS_ADD >= 16'd16) && ({16'd0, bus.BUS_ADD} < 32'(MEM_BYTES + 16));
  assign mem_off   = bus.BUS_ADD - 16'd16;
  assign reg_sel   = bus.BUS_ADD[3:0];
  assign reg_wr    = bus.BUS_WR && reg_hit;
  assign soft_rst  = reg_wr && (reg_sel == 4'd0);
  assign bus_start = reg_wr && (reg_sel == 4'd1);
  assign abort_req = reg_wr && (reg_sel == 4'd12);

  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge BUS_CLK) begin
    if (bus.BUS_WR && mem_hit) begin
      mem_q[mem_off[AW-1:0]] <= bus.BUS_DATA_IN;
    end
  end

  // configuration registers
  logic                 en_ext_q, en_ext_d;
  logic [15:0]          size_q, size_d;
  logic [15:0]          rep_cnt_q, rep_cnt_d;
  logic [15:0]          rep_dly_q, rep_dly_d;
  logic [15:0]          start_addr_q, start_addr_d;
  logic [OUT_LINES-1:0] out_en_q, out_en_d;

  always_comb begin
    en_ext_d     = en_ext_q;
    size_d       = size_q;
    rep_cnt_d    = rep_cnt_q;
    rep_dly_d    = rep_dly_q;
    start_addr_d = start_addr_q;
    out_en_d     = out_en_q;
    if (reg_wr) begin
      case (reg_sel)
        4'd2:    en_ext_d            = bus.BUS_DATA_IN[0];
        4'd3:    size_d[7:0]         = bus.BUS_DATA_IN;
        4'd4:    size_d[15:8]        = bus.BUS_DATA_IN;
        4'd5:    rep_cnt_d[7:0]      = bus.BUS_DATA_IN;
        4'd6:    rep_cnt_d[15:8]     = bus.BUS_DATA_IN;
        4'd7:    rep_dly_d[7:0]      = bus.BUS_DATA_IN;
        4'd8:    rep_dly_d[15:8]     = bus.BUS_DATA_IN;
        4'd9:    start_addr_d[7:0]   = bus.BUS_DATA_IN;
        4'd10:   start_addr_d[15:8]  = bus.BUS_DATA_IN;
        4'd11:   out_en_d            = bus.BUS_DATA_IN[OUT_LINES-1:0];
        default: ;
      endcase
    end
  end

  // read path
  logic       cmd_ready_q, cmd_ready_d;
  logic [7:0] rd_data, out_en_rd;
  logic [7:0] bus_data_out_q, bus_data_out_d;

  always_comb begin
    out_en_rd = 8'd0;
    out_en_rd[OUT_LINES-1:0] = out_en_q;
    rd_data = 8'd0;
    if (mem_hit) begin
      rd_data = mem_q[mem_off[AW-1:0]];
    end else if (reg_hit) begin
      case (reg_sel)
        4'd0:    rd_data = VERSION;
        4'd1:    rd_data = {7'd0, cmd_ready_q};
        4'd2:    rd_data = {7'd0, en_ext_q};
        4'd3:    rd_data = size_q[7:0];
        4'd4:    rd_data = size_q[15:8];
        4'd5:    rd_data = rep_cnt_q[7:0];
        4'd6:    rd_data = rep_cnt_q[15:8];
        4'd7:    rd_data = rep_dly_q[7:0];
        4'd8:    rd_data = rep_dly_q[15:8];
        4'd9:    rd_data = start_addr_q[7:0];
        4'd10:   rd_data = start_addr_q[15:8];
        4'd11:   rd_data = out_en_rd;
        default: rd_data = 8'd0;
      endcase
    end
    bus_data_out_d = bus.BUS_RD ? rd_data : bus_data_out_q;
  end

  // sequencer
  logic [1:0]           state_q, state_d;
  logic [15:0]          bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [15:0]          rem_q, rem_d;
  logic [15:0]          gap_q, gap_d;
  logic [15:0]          snap_size_q, snap_size_d;
  logic [15:0]          snap_dly_q, snap_dly_d;
  logic [15:0]          snap_addr_q, snap_addr_d;
  logic [OUT_LINES-1:0] snap_en_q, snap_en_d;
  logic                 snap_inf_q, snap_inf_d;
  logic [OUT_LINES-1:0] cmd_data_q, cmd_data_d;
  logic                 ready_flag_q, ready_flag_d;
  logic                 start_flag_q, start_flag_d;

  logic        start_req, fetch, cur_bit, last_bit, more_reps;
  logic [15:0] seq_off;
  logic [7:0]  fetch_byte;

  assign start_req  = bus_start || (CMD_EXT_START && en_ext_q);
  assign seq_off    = snap_addr_q + {3'd0, bit_q[15:3]};
  assign fetch_byte = mem_q[seq_off[AW-1:0]];
  // Each byte is read from memory once, at its first bit, then shifted out of shreg_q.
  assign fetch      = (bit_q[2:0] == 3'd0);
  assign cur_bit    = fetch ? fetch_byte[7] : shreg_q[7];
  assign last_bit   = (bit_q == snap_size_q - 16'd1);
  assign more_reps  = snap_inf_q || (rem_q != 16'd1);

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    snap_size_d  = snap_size_q;
    snap_dly_d   = snap_dly_q;
    snap_addr_d  = snap_addr_q;
    snap_en_d    = snap_en_q;
    snap_inf_d   = snap_inf_q;
    cmd_data_d   = '0;
    start_flag_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req && (size_q != 16'd0)) begin
          state_d      = ST_SEND;
          bit_d        = 16'd0;
          snap_size_d  = size_q;
          snap_dly_d   = rep_dly_q;
          snap_addr_d  = start_addr_q;
          snap_en_d    = out_en_q;
          rem_d        = rep_cnt_q;
          snap_inf_d   = (rep_cnt_q == 16'd0);
          start_flag_d = 1'b1;
        end
      end
      ST_SEND: begin
        cmd_data_d = {OUT_LINES{cur_bit}} & snap_en_q;
        shreg_d    = fetch ? {fetch_byte[6:0], 1'b0} : {shreg_q[6:0], 1'b0};
        bit_d      = bit_q + 16'd1;
        if (last_bit) begin
          bit_d = 16'd0;
          if (more_reps) begin
            if (!snap_inf_q) rem_d = rem_q - 16'd1;
            if (snap_dly_q != 16'd0) begin
              state_d = ST_GAP;
              gap_d   = snap_dly_q - 16'd1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 16'd0) state_d = ST_SEND;
        else                gap_d   = gap_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_req && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      cmd_data_d = '0;
    end
    // READY trails the FSM by one cycle so it stays low while the last bit is on the line.
    cmd_ready_d  = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    ready_flag_d = cmd_ready_d && !cmd_ready_q;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || soft_rst) begin
      en_ext_q       <= 1'b0;
      size_q         <= 16'd0;
      rep_cnt_q      <= 16'd1;
      rep_dly_q      <= 16'd0;
      start_addr_q   <= 16'd0;
      out_en_q       <= '1;
      bus_data_out_q <= 8'd0;
      state_q        <= ST_IDLE;
      bit_q          <= 16'd0;
      shreg_q        <= 8'd0;
      rem_q          <= 16'd0;
      gap_q          <= 16'd0;
      snap_size_q    <= 16'd0;
      snap_dly_q     <= 16'd0;
      snap_addr_q    <= 16'd0;
      snap_en_q      <= '0;
      snap_inf_q     <= 1'b0;
      cmd_data_q     <= '0;
      cmd_ready_q    <= 1'b1;
      ready_flag_q   <= 1'b0;
      start_flag_q   <= 1'b0;
    end else begin
      en_ext_q       <= en_ext_d;
      size_q         <= size_d;
      rep_cnt_q      <= rep_cnt_d;
      rep_dly_q      <= rep_dly_d;
      start_addr_q   <= start_addr_d;
      out_en_q       <= out_en_d;
      bus_data_out_q <= bus_data_out_d;
      state_q        <= state_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      rem_q          <= rem_d;
      gap_q          <= gap_d;
      snap_size_q    <= snap_size_d;
      snap_dly_q     <= snap_dly_d;
      snap_addr_q    <= snap_addr_d;
      snap_en_q      <= snap_en_d;
      snap_inf_q     <= snap_inf_d;
      cmd_data_q     <= cmd_data_d;
      cmd_ready_q    <= cmd_ready_d;
      ready_flag_q   <= ready_flag_d;
      start_flag_q   <= start_flag_d;
    end
  end

  assign bus.BUS_DATA_OUT = bus_data_out_q;
  assign CMD_DATA         = cmd_data_q;
  assign CMD_READY        = cmd_ready_q;
  assign CMD_READY_FLAG   = ready_flag_q;
  assign CMD_START_FLAG   = start_flag_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_cmd_seq_multi.sv
// Directed bench for cmd_seq_multi with a 16-byte memory so address wrap is reachable.
module tb_cmd_seq_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_start = 1'b0;
  logic [3:0] cmd_data;
  logic       ready, rflag, sflag;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  cmd_seq_multi_if bus_if();

  cmd_seq_multi #(.MEM_BYTES(16), .OUT_LINES(4), .VERSION(8'd2)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .bus(bus_if), .CMD_EXT_START(ext_start),
    .CMD_DATA(cmd_data), .CMD_READY(ready), .CMD_READY_FLAG(rflag),
    .CMD_START_FLAG(sflag), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.BUS_ADD = a; bus_if.BUS_DATA_IN = d; bus_if.BUS_WR = 1'b1;
    tick();
    bus_if.BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus_if.BUS_ADD = a; bus_if.BUS_RD = 1'b1;
    tick();
    bus_if.BUS_RD = 1'b0;
    d = bus_if.BUS_DATA_OUT;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    checks++; if (cmd_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", cmd_data); end
    checks++; if (ready !== 1'b1 || rflag !== 1'b0 || sflag !== 1'b0) begin errors++; $display("FAIL reset_ctl: ready %b rflag %b sflag %b", ready, rflag, sflag); end
    checks++; if (bus_if.BUS_DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h exp 00", bus_if.BUS_DATA_OUT); end
    bus_read(16'd0, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL version: got %h exp 02", rd); end
    bus_read(16'd5, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL rep_default: got %h exp 01", rd); end
    bus_read(16'd11, rd);
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL out_en_default: got %h exp 0f", rd); end
    bus_read(16'd1, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL ready_read: got %h exp 01", rd); end
    bus_write(16'd13, 8'h55);
    bus_read(16'd13, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reserved_read: got %h exp 00", rd); end
    bus_write(16'd11, 8'h03);
    bus_read(16'd0, rd);
    bus_write(16'd0, 8'h00);
    checks++; if (bus_if.BUS_DATA_OUT !== 8'h00) begin errors++; $display("FAIL soft_rst_dout: got %h exp 00", bus_if.BUS_DATA_OUT); end
    bus_read(16'd11, rd);
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL soft_rst_out_en: got %h exp 0f", rd); end
  endtask

  task automatic test_single_shot();
    logic [11:0] exp_bits;
    logic        b;
    exp_bits = 12'hA53;
    bus_write(16'd16, 8'hA5);
    bus_write(16'd17, 8'h3C);
    bus_write(16'd3, 8'd12);
    bus_write(16'd1, 8'h00);
    checks++; if (sflag !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL single_start: sflag %b ready %b exp 1 0", sflag, ready); end
    for (int k = 0; k < 12; k++) begin
      tick();
      b = exp_bits[11-k];
      checks++; if (cmd_data !== {4{b}} || ready !== 1'b0) begin errors++; $display("FAIL single_bit%0d: data %h ready %b exp %h 0", k, cmd_data, ready, {4{b}}); end
    end
    tick();
    checks++; if (cmd_data !== 4'h0 || ready !== 1'b1 || rflag !== 1'b1) begin errors++; $display("FAIL single_done: data %h ready %b rflag %b exp 0 1 1", cmd_data, ready, rflag); end
    tick();
    checks++; if (rflag !== 1'b0) begin errors++; $display("FAIL single_flag_pulse: rflag %b exp 0", rflag); end
  endtask

  task automatic test_repeat_gap();
    logic [15:0] pat;
    logic        b;
    pat = 16'hF3CF;
    bus_write(16'd16, 8'hF0);
    bus_write(16'd3, 8'd4);
    bus_write(16'd5, 8'd3);
    bus_write(16'd7, 8'd2);
    bus_write(16'd1, 8'h00);
    for (int k = 0; k < 16; k++) begin
      tick();
      b = pat[15-k];
      checks++; if (cmd_data[0] !== b || ready !== 1'b0) begin errors++; $display("FAIL repeat_cyc%0d: data %b ready %b exp %b 0", k, cmd_data[0], ready, b); end
    end
    tick();
    checks++; if (ready !== 1'b1 || rflag !== 1'b1 || cmd_data !== 4'h0) begin errors++; $display("FAIL repeat_done: ready %b rflag %b data %h exp 1 1 0", ready, rflag, cmd_data); end
    bus_write(16'd5, 8'd1);
    bus_write(16'd7, 8'd0);
  endtask

  task automatic test_wrap_mask();
    logic [15:0] pat;
    logic        b;
    pat = 16'hC3A5;
    bus_write(16'd31, 8'hC3);
    bus_write(16'd16, 8'hA5);
    bus_write(16'd9, 8'd15);
    bus_write(16'd3, 8'd16);
    bus_write(16'd11, 8'h05);
    bus_write(16'd1, 8'h00);
    for (int k = 0; k < 16; k++) begin
      tick();
      b = pat[15-k];
      checks++; if (cmd_data !== {1'b0, b, 1'b0, b}) begin errors++; $display("FAIL wrap_bit%0d: got %h exp %h", k, cmd_data, {1'b0, b, 1'b0, b}); end
    end
    tick();
    checks++; if (ready !== 1'b1 || rflag !== 1'b1) begin errors++; $display("FAIL wrap_done: ready %b rflag %b exp 1 1", ready, rflag); end
    bus_write(16'd11, 8'h0F);
    bus_write(16'd9, 8'd0);
  endtask

  task automatic test_infinite_abort();
    logic [7:0] byte_v;
    logic       b;
    byte_v = 8'hA5;
    bus_write(16'd3, 8'd8);
    bus_write(16'd5, 8'd0);
    bus_write(16'd1, 8'h00);
    for (int k = 0; k < 40; k++) begin
      tick();
      b = byte_v[7-(k%8)];
      checks++; if (cmd_data !== {4{b}} || ready !== 1'b0) begin errors++; $display("FAIL inf_bit%0d: data %h ready %b exp %h 0", k, cmd_data, ready, {4{b}}); end
    end
    bus_write(16'd12, 8'h00);
    checks++; if (cmd_data !== 4'h0) begin errors++; $display("FAIL abort_data: got %h exp 0", cmd_data); end
    tick();
    checks++; if (ready !== 1'b1 || rflag !== 1'b1) begin errors++; $display("FAIL abort_ready: ready %b rflag %b exp 1 1", ready, rflag); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (cmd_data !== 4'h0 || ready !== 1'b1) begin errors++; $display("FAIL abort_quiet%0d: data %h ready %b", k, cmd_data, ready); end
    end
    bus_write(16'd5, 8'd1);
  endtask

  task automatic test_start_guards();
    bus_write(16'd3, 8'd0);
    bus_write(16'd1, 8'h00);
    checks++; if (sflag !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL zero_size: sflag %b ready %b exp 0 1", sflag, ready); end
    bus_write(16'd3, 8'd8);
    ext_start = 1'b1; tick(); ext_start = 1'b0;
    checks++; if (sflag !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL ext_disabled: sflag %b ready %b exp 0 1", sflag, ready); end
    bus_write(16'd2, 8'h01);
    ext_start = 1'b1; tick(); ext_start = 1'b0;
    checks++; if (sflag !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL ext_enabled: sflag %b ready %b exp 1 0", sflag, ready); end
    bus_write(16'd1, 8'h00);
    checks++; if (sflag !== 1'b0 || state_dbg !== 2'd1) begin errors++; $display("FAIL busy_start: sflag %b state %0d exp 0 1", sflag, state_dbg); end
    for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_timeout: ready %b exp 1", ready); end
    bus_write(16'd2, 8'h00);
    tick();
    bus_write(16'd12, 8'h00);
    checks++; if (ready !== 1'b1 || rflag !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL idle_abort: ready %b rflag %b state %0d", ready, rflag, state_dbg); end
  endtask

  task automatic test_snapshot_reset();
    logic [7:0] byte_v;
    logic [7:0] rd;
    byte_v = 8'hA5;
    bus_write(16'd1, 8'h00);
    tick();
    checks++; if (cmd_data[0] !== byte_v[7]) begin errors++; $display("FAIL snap_bit0: got %b exp %b", cmd_data[0], byte_v[7]); end
    bus_write(16'd3, 8'd2);
    checks++; if (cmd_data[0] !== byte_v[6]) begin errors++; $display("FAIL snap_bit1: got %b exp %b", cmd_data[0], byte_v[6]); end
    for (int k = 2; k < 8; k++) begin
      tick();
      checks++; if (cmd_data[0] !== byte_v[7-k] || ready !== 1'b0) begin errors++; $display("FAIL snap_bit%0d: data %b ready %b exp %b 0", k, cmd_data[0], ready, byte_v[7-k]); end
    end
    tick();
    checks++; if (ready !== 1'b1 || rflag !== 1'b1) begin errors++; $display("FAIL snap_done: ready %b rflag %b exp 1 1", ready, rflag); end
    bus_write(16'd3, 8'd8);
    bus_write(16'd5, 8'd5);
    bus_write(16'd1, 8'h00);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (cmd_data !== 4'h0 || ready !== 1'b1 || state_dbg !== 2'd0) begin errors++; $display("FAIL rst_mid: data %h ready %b state %0d exp 0 1 0", cmd_data, ready, state_dbg); end
    bus_read(16'd5, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL rst_rep: got %h exp 01", rd); end
    bus_read(16'd3, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_size: got %h exp 00", rd); end
    bus_read(16'd16, rd);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL mem0_kept: got %h exp a5", rd); end
    bus_read(16'd31, rd);
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL mem15_kept: got %h exp c3", rd); end
  endtask

  initial begin
    bus_if.BUS_ADD = 16'd0; bus_if.BUS_DATA_IN = 8'd0;
    bus_if.BUS_RD = 1'b0; bus_if.BUS_WR = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    test_reset();
    test_single_shot();
    test_repeat_gap();
    test_wrap_mask();
    test_infinite_abort();
    test_start_guards();
    test_snapshot_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_seq_multi.md
Name: cmd_seq_multi

Overview:
- Single-clock, parametrised successor to the command sequencer.
- Serialises a bit stream held in a bus-writable byte memory MSB-first and broadcasts it onto OUT_LINES command outputs, each gated by a per-line enable mask.
- Adds a configurable start address, a programmable idle gap between repetitions, infinite-repeat mode, abort, and a snapshot of the configuration at start.
- Sits on the 8-bit register bus next to the other FE command/readout blocks.

Parameters:
- MEM_BYTES, 2048, command memory depth in bytes; power of two, 16..65536.
- OUT_LINES, 4, number of CMD_DATA output lines, 1..8.
- VERSION, 8'd2, constant returned on a read of address 0.

Ports:
- BUS_CLK  in  1  single clock for bus and sequencer.
- BUS_RST  in  1  reset; synchronous, active-high.
- BUS_ADD  in  16  byte address.
- BUS_DATA_IN  in  8  write data.
- BUS_RD  in  1  read strobe.
- BUS_WR  in  1  write strobe.
- BUS_DATA_OUT  out  8  read data, registered.
- CMD_EXT_START  in  1  external start request, sampled every cycle.
- CMD_DATA  out  OUT_LINES  serial data; line i = stream bit AND OUT_EN[i].
- CMD_READY  out  1  high while IDLE.
- CMD_READY_FLAG  out  1  one-cycle pulse on SEND/GAP->IDLE.
- CMD_START_FLAG  out  1  one-cycle pulse when a start is accepted.

Behaviour:
- Register map. Multi-byte fields are little-endian.
  - 0: write = soft reset; read = VERSION.
  - 1: write = start; read = {7'b0, READY}.
  - 2: bit0 EN_EXT_START.
  - 3-4: CMD_SIZE, in bits.
  - 5-6: REPEAT_COUNT; 0 = infinite.
  - 7-8: REPEAT_DELAY, in cycles.
  - 9-10: START_ADDR, in bytes.
  - 11: OUT_EN, bits above OUT_LINES ignored.
  - 12: write = abort.
  - 13-15: reserved, read 0.
  - 16..16+MEM_BYTES-1: command memory.
- Register reset defaults: REPEAT_COUNT = 1, OUT_EN = all ones, all other fields 0.
- Reset and soft reset (BUS_RST, or a write to addr 0):
  - Registers return to defaults; the memory is not cleared.
  - State goes to IDLE.
  - CMD_DATA = 0, CMD_READY = 1, both flags = 0, BUS_DATA_OUT = 0.
- Bus reads: BUS_DATA_OUT updates on the posedge after the address is presented (1-cycle latency). Reserved and out-of-range addresses read 0; writes to them are ignored.
- States: IDLE, SEND, GAP.
- Start:
  - Trigger is a write to addr 1, or CMD_EXT_START=1 with EN_EXT_START=1.
  - A start is accepted only in IDLE with CMD_SIZE != 0; otherwise it is ignored and sets no flag.
  - Simultaneous bus and external start counts as one start.
  - At the acceptance edge T: snapshot CMD_SIZE, REPEAT_COUNT, REPEAT_DELAY, START_ADDR and OUT_EN. Later register writes do not affect the running sequence.
  - CMD_START_FLAG is high for the cycle after T.
- SEND:
  - Entered at T+1. Stream bit k (k = 0..CMD_SIZE-1) is bit 7-(k%8) of memory byte (START_ADDR + k/8) mod MEM_BYTES.
  - Bit k is driven on CMD_DATA during cycle T+2+k; CMD_DATA is registered.
- After the last bit of a repetition:
  - Remaining repetitions > 0 and REPEAT_DELAY = 0: the next repetition's bit 0 follows back-to-back.
  - Remaining repetitions > 0 and REPEAT_DELAY = D > 0: go to GAP and hold CMD_DATA = 0 for exactly D cycles, then SEND.
  - No repetitions remain: go to IDLE; CMD_DATA = 0 from the cycle after the last bit.
- REPEAT_COUNT = 0 repeats until abort or reset.
- Repetition counter is 16-bit; a count of 65535 must complete 65535 repetitions without wrap.
- Abort (write to addr 12): from SEND/GAP, go to IDLE on the next edge; CMD_DATA = 0 from the following cycle. CMD_READY_FLAG pulses as for normal completion. Abort in IDLE has no effect.
- CMD_READY: low from T+1 through the cycle the last bit (or last gap cycle on abort) is driven. Returns high together with the CMD_READY_FLAG pulse.
- Write to addr 1 and addr 12 in the same state:
  - In IDLE, the start wins.
  - While busy, the abort wins and the start is ignored.
- Memory write during SEND: permitted. The new value takes effect if the byte has not yet been fetched, and must not glitch the bit being driven.

Test Plan:
- Single shot: mem[0..1] = 8'hA5, 8'h3C; CMD_SIZE = 12; write addr 1 at T -> CMD_DATA[0] = 1,0,1,0,0,1,0,1,0,0,1,1 on cycles T+2..T+13; then 0; CMD_READY_FLAG pulse at T+14.
- Repeat with gap: CMD_SIZE = 4, REPEAT_COUNT = 3, REPEAT_DELAY = 2, mem[0] = 8'hF0 -> pattern 1111 00 1111 00 1111; READY high after 16 stream cycles.
- Start address, wrap and mask: MEM_BYTES = 16, START_ADDR = 15, CMD_SIZE = 16, OUT_EN = 4'b0101 -> byte 15 then byte 0 on lines 0 and 2; lines 1 and 3 stay 0.
- Infinite and abort: REPEAT_COUNT = 0, CMD_SIZE = 8; abort after 40 cycles -> output 0 and READY = 1 within 2 cycles; no further bits.
- Start guards: start with CMD_SIZE = 0 -> no START_FLAG, READY stays 1. Start while busy -> ignored. EXT_START with EN_EXT_START = 0 -> ignored; with EN_EXT_START = 1 -> START_FLAG pulse.
- Snapshot and reset: change CMD_SIZE mid-SEND -> original length completes. BUS_RST mid-SEND -> CMD_DATA = 0, READY = 1 next cycle; readback REPEAT_COUNT = 1; memory contents intact.
